// File: rtl/dut_out_streamer.sv
// dut_out_streamer: buffers DUT result words in a FWFT FIFO and emits them as AXI4-Stream packets
module dut_out_streamer #(
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_BEATS  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cap_valid,
  input  logic [DATA_WIDTH-1:0]         cap_data,
  input  logic                          cap_last,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic                          clear,
  output logic                          overflow,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PKT_BEATS + 1);
  localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] CNT_LAST = CW'(PKT_BEATS - 1);
  logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [AW:0]         r_level;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf;
  logic [15:0]         r_drop;
  logic [DATA_WIDTH:0] w_head;
  logic                w_valid, w_rd, w_full, w_wr, w_drop, w_last;
  assign w_head  = r_mem[r_rptr];
  assign w_valid = r_level != '0;
  assign w_rd    = w_valid & m_axis_tready;
  assign w_full  = r_level == DEPTH;
  assign w_wr    = cap_valid & (~w_full | w_rd);
  assign w_drop  = cap_valid & w_full & ~w_rd;
  assign w_last  = cap_last | (r_cnt == CNT_LAST);
  assign m_axis_tvalid = w_valid;
  assign m_axis_tdata  = w_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = w_valid & w_head[DATA_WIDTH];
  assign m_axis_tkeep  = '1;
  assign overflow      = r_ovf;
  assign drop_cnt      = r_drop;
  assign level         = r_level;
  // storage array: each entry carries its packet-close tag above the data
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {w_last, cap_data};
  end
  // pointers, occupancy and write-side beat counter; reset discards any partial packet
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
    end
  end
  // sticky overflow flag and saturating drop counter; clear beats a coincident drop
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf  <= 1'b1;
      r_drop <= (r_drop == 16'hFFFF) ? r_drop : r_drop + 16'd1;
    end
  end
endmodule

// File: doc/dut_out_streamer.md
Name: dut_out_streamer

Overview:
- Transmit-side companion to the DUT wrapper's output bus.
- Captures DUT result words qualified by a valid strobe and buffers them in a FIFO.
- Emits them as AXI4-Stream packets toward the QDMA C2H path, with tlast framing every PKT_BEATS beats or on an explicit last marker.
- Handles C2H backpressure and counts words dropped on overflow.

Parameters:
- DATA_WIDTH, 256, width of the DUT output word and of m_axis_tdata; must be a multiple of 8.
- FIFO_DEPTH, 16, number of buffered words; power of two, at least 2.
- PKT_BEATS, 8, beats per packet when cap_last is not asserted; at least 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cap_valid  in  1  cap_data holds a DUT result word this cycle
- cap_data  in  DATA_WIDTH  DUT result word
- cap_last  in  1  force this word to close the current packet (sampled with cap_valid)
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tkeep  out  DATA_WIDTH/8  byte enables
- m_axis_tvalid  out  1  stream valid
- m_axis_tlast  out  1  last beat of packet
- m_axis_tready  in  1  downstream ready
- clear  in  1  clears overflow and drop_cnt
- overflow  out  1  sticky: at least one word dropped
- drop_cnt  out  16  saturating count of dropped words
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - FIFO emptied; level=0.
  - m_axis_tvalid=0, m_axis_tlast=0, overflow=0, drop_cnt=0.
  - Write-side beat counter cleared.
  - Reset mid-packet discards all buffered words and any partial packet; no tlast is emitted for them.
- Write side:
  - Write occurs when cap_valid=1 and (level<FIFO_DEPTH, or a read happens in the same cycle).
  - Each entry stores {last_tag, data}.
  - last_tag=1 when cap_last=1, or when the write beat counter equals PKT_BEATS-1.
  - The counter increments per written word and returns to 0 after any tagged-last write.
- Overflow:
  - Condition: cap_valid=1, level==FIFO_DEPTH, and no read this cycle.
  - The word is dropped, the beat counter is not advanced, overflow is set, and drop_cnt increments, saturating at 16'hFFFF.
- Read side (first-word-fall-through):
  - m_axis_tvalid = (level!=0).
  - m_axis_tdata and m_axis_tlast reflect the FIFO head.
  - m_axis_tdata=0 and m_axis_tlast=0 whenever tvalid=0.
  - m_axis_tkeep is all ones.
  - A read occurs on tvalid && tready.
  - Once asserted, tvalid/tdata/tlast stay stable until accepted (AXI rule); tvalid never depends on tready.
- Latency:
  - A word written at edge N is visible on m_axis_* after edge N, i.e. in cycle N+1.
  - Minimum capture-to-output latency is 1 cycle.
  - Sustained throughput is 1 word/cycle with tready=1.
- Simultaneous read and write: level unchanged. This holds when full (write accepted, no drop) and when level==1 (the new word becomes head the next cycle, with no bubble beyond FWFT).
- level updates:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both or neither.
- Pointers wrap modulo FIFO_DEPTH.
- clear: overflow=0 and drop_cnt=0 next cycle. If a drop coincides with clear, clear wins and the result is drop_cnt=0.
- PKT_BEATS=1: every word is tagged last.

Test Plan:
- Reset, then 16 consecutive cap_valid words 0..15 with tready=1 and PKT_BEATS=8:
  - 16 beats in order, data 0..15.
  - tlast on words 7 and 15; first tvalid one cycle after the first capture.
  - overflow=0.
- tready=0 while 20 words are written (FIFO_DEPTH=16):
  - level saturates at 16; overflow=1; drop_cnt=4.
  - After tready=1, exactly words 0..15 emerge.
- Full FIFO, tready=1 and cap_valid=1 in the same cycle: the write is accepted, level stays 16, and drop_cnt is unchanged.
- cap_last=1 on word 2 of a packet, followed by 8 more words: tlast on words 2 and 10, confirming the counter restarted.
- tready toggled pseudo-randomly during a 64-word stream: tdata/tvalid/tlast held stable while tready=0, and the output sequence is identical to the input.
- rst_n=0 asserted with 5 words buffered mid-packet, then 8 new words written: level=0 and tvalid=0 after reset; the new packet carries tlast on its 8th word.
